// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decoded-instruction bundle from ID into the ID/EX register
interface id_ex_stage_if #(
  parameter int W  = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_wr_reg;
  logic [W-1:0]  id_rs_data;
  logic [W-1:0]  id_rt_data;
  logic [W-1:0]  id_imm;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic          load_use_stall;

  modport master (
    output id_valid, id_alu_op, id_funct, id_alu_src, id_rs, id_rt, id_wr_reg,
           id_rs_data, id_rt_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg,
    input  load_use_stall
  );

  modport slave (
    input  id_valid, id_alu_op, id_funct, id_alu_src, id_rs, id_rt, id_wr_reg,
           id_rs_data, id_rt_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg,
    output load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode, forwarding and load-use detect
module id_ex_stage #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  id_ex_stage_if.slave  id,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_wr_reg,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_wr_reg,
  input  logic [W-1:0]  memwb_result,
  output logic          ex_valid,
  output logic [3:0]    alu_ctl,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [W-1:0]  ex_store_data,
  output logic [RW-1:0] ex_wr_reg,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_illegal
);

  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_BAD = 4'd15;

  logic          ex_alu_src;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [W-1:0]  ex_rs_data;
  logic [W-1:0]  ex_rt_data;
  logic [W-1:0]  ex_imm;

  logic [3:0]    dec_ctl;
  logic          dec_bad;
  logic          stall;

  always_comb begin
    dec_ctl = CTL_ADD;
    dec_bad = 1'b0;
    case (id.id_alu_op)
      2'b00: dec_ctl = 4'd2;
      2'b01: dec_ctl = 4'd6;
      2'b11: dec_ctl = 4'd1;
      default: begin
        case (id.id_funct)
          6'b100000, 6'b100001: dec_ctl = 4'd2;
          6'b100010, 6'b100011: dec_ctl = 4'd6;
          6'b100100:            dec_ctl = 4'd0;
          6'b100101:            dec_ctl = 4'd1;
          6'b100110:            dec_ctl = 4'd13;
          6'b100111:            dec_ctl = 4'd12;
          default: begin
            dec_ctl = CTL_BAD;
            dec_bad = 1'b1;
          end
        endcase
      end
    endcase
  end

  // A load in EX whose result is read by ID cannot be forwarded in time.
  always_comb begin
    stall = ex_valid & ex_mem_read & (ex_wr_reg != '0) & id.id_valid &
            ((ex_wr_reg == id.id_rs) | ((ex_wr_reg == id.id_rt) & ~id.id_alu_src));
  end

  assign id.load_use_stall = stall;

  function automatic logic [W-1:0] fwd(
    input logic [RW-1:0] r,
    input logic [W-1:0]  captured,
    input logic          em_we,
    input logic [RW-1:0] em_reg,
    input logic [W-1:0]  em_val,
    input logic          mw_we,
    input logic [RW-1:0] mw_reg,
    input logic [W-1:0]  mw_val
  );
    if (em_we && (em_reg != '0) && (em_reg == r))      return em_val;
    else if (mw_we && (mw_reg != '0) && (mw_reg == r)) return mw_val;
    else                                               return captured;
  endfunction

  always_comb begin
    alu_a = fwd(ex_rs, ex_rs_data, exmem_reg_write, exmem_wr_reg, exmem_result,
                memwb_reg_write, memwb_wr_reg, memwb_result);
    ex_store_data = fwd(ex_rt, ex_rt_data, exmem_reg_write, exmem_wr_reg, exmem_result,
                        memwb_reg_write, memwb_wr_reg, memwb_result);
    alu_b = ex_alu_src ? ex_imm : ex_store_data;
  end

  // Data registers survive flush/bubble untouched; only the live/control bits are killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_illegal    <= 1'b0;
      alu_ctl       <= CTL_ADD;
      ex_alu_src    <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_wr_reg     <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
    end else if (flush || (!hold && stall)) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!hold) begin
      ex_valid      <= id.id_valid;
      ex_reg_write  <= id.id_reg_write & id.id_valid;
      ex_mem_read   <= id.id_mem_read & id.id_valid;
      ex_mem_write  <= id.id_mem_write & id.id_valid;
      ex_mem_to_reg <= id.id_mem_to_reg & id.id_valid;
      ex_illegal    <= dec_bad & id.id_valid;
      alu_ctl       <= dec_ctl;
      ex_alu_src    <= id.id_alu_src;
      ex_rs         <= id.id_rs;
      ex_rt         <= id.id_rt;
      ex_wr_reg     <= id.id_wr_reg;
      ex_rs_data    <= id.id_rs_data;
      ex_rt_data    <= id.id_rt_data;
      ex_imm        <= id.id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
  localparam int W  = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n, hold, flush;
  logic          exmem_reg_write, memwb_reg_write;
  logic [RW-1:0] exmem_wr_reg, memwb_wr_reg;
  logic [W-1:0]  exmem_result, memwb_result;
  logic          ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [3:0]    alu_ctl;
  logic [W-1:0]  alu_a, alu_b, ex_store_data;
  logic [RW-1:0] ex_wr_reg;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage_if #(.W(W), .RW(RW)) idif ();

  id_ex_stage #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id(idif.slave),
    .exmem_reg_write(exmem_reg_write), .exmem_wr_reg(exmem_wr_reg), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_wr_reg(memwb_wr_reg), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in EX, as a record of what ID handed over.
  logic          m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill, m_src;
  logic [3:0]    m_ctl;
  logic [RW-1:0] m_rs, m_rt, m_wr;
  logic [W-1:0]  m_rsd, m_rtd, m_imm;

  function automatic logic [3:0] op_code(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'd2;
    if (op == 2'b01) return 4'd6;
    if (op == 2'b11) return 4'd1;
    case (f)
      6'h20, 6'h21: return 4'd2;
      6'h22, 6'h23: return 4'd6;
      6'h24:        return 4'd0;
      6'h25:        return 4'd1;
      6'h26:        return 4'd13;
      6'h27:        return 4'd12;
      default:      return 4'd15;
    endcase
  endfunction

  function automatic logic m_stall();
    return m_valid && m_mr && (m_wr != 0) && idif.id_valid &&
           (idif.id_rs == m_wr || (!idif.id_alu_src && idif.id_rt == m_wr));
  endfunction

  function automatic logic [W-1:0] m_fwd(input logic [RW-1:0] r, input logic [W-1:0] d);
    if (r == 0) return d;
    if (exmem_reg_write && exmem_wr_reg == r) return exmem_result;
    if (memwb_reg_write && memwb_wr_reg == r) return memwb_result;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0; m_ill <= 0; m_src <= 0;
      m_ctl <= 4'd2; m_rs <= 0; m_rt <= 0; m_wr <= 0; m_rsd <= 0; m_rtd <= 0; m_imm <= 0;
    end else if (flush || (!hold && m_stall())) begin
      m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0; m_ill <= 0;
    end else if (!hold) begin
      m_valid <= idif.id_valid;
      m_rw    <= idif.id_valid && idif.id_reg_write;
      m_mr    <= idif.id_valid && idif.id_mem_read;
      m_mw    <= idif.id_valid && idif.id_mem_write;
      m_m2r   <= idif.id_valid && idif.id_mem_to_reg;
      m_ctl   <= op_code(idif.id_alu_op, idif.id_funct);
      m_ill   <= idif.id_valid && op_code(idif.id_alu_op, idif.id_funct) == 4'd15;
      m_src   <= idif.id_alu_src;
      m_rs <= idif.id_rs; m_rt <= idif.id_rt; m_wr <= idif.id_wr_reg;
      m_rsd <= idif.id_rs_data; m_rtd <= idif.id_rt_data; m_imm <= idif.id_imm;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ex_valid", W'(ex_valid), W'(m_valid));
      chk("load_use_stall", W'(idif.load_use_stall), W'(m_stall()));
      chk("ex_reg_write", W'(ex_reg_write), W'(m_rw));
      chk("ex_mem_read", W'(ex_mem_read), W'(m_mr));
      chk("ex_mem_write", W'(ex_mem_write), W'(m_mw));
      chk("ex_mem_to_reg", W'(ex_mem_to_reg), W'(m_m2r));
      chk("ex_illegal", W'(ex_illegal), W'(m_ill));
      chk("alu_ctl", W'(alu_ctl), W'(m_ctl));
      if (m_valid) begin
        chk("ex_wr_reg", W'(ex_wr_reg), W'(m_wr));
        chk("alu_a", alu_a, m_fwd(m_rs, m_rsd));
        chk("ex_store_data", ex_store_data, m_fwd(m_rt, m_rtd));
        chk("alu_b", alu_b, m_src ? m_imm : m_fwd(m_rt, m_rtd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic src,
                       input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] wr,
                       input logic [W-1:0] rsd, input logic [W-1:0] rtd, input logic [W-1:0] imm,
                       input logic rw, input logic mr, input logic mw, input logic m2r);
    idif.id_valid = v; idif.id_alu_op = op; idif.id_funct = f; idif.id_alu_src = src;
    idif.id_rs = rs; idif.id_rt = rt; idif.id_wr_reg = wr;
    idif.id_rs_data = rsd; idif.id_rt_data = rtd; idif.id_imm = imm;
    idif.id_reg_write = rw; idif.id_mem_read = mr; idif.id_mem_write = mw; idif.id_mem_to_reg = m2r;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_wr_reg = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_wr_reg = 0; memwb_result = 0;
  endtask

  // {alu_op, funct, expected alu_ctl}
  logic [11:0] tbl [12] = '{
    {2'b00, 6'h00, 4'd2},  {2'b01, 6'h00, 4'd6},  {2'b11, 6'h00, 4'd1},
    {2'b10, 6'h20, 4'd2},  {2'b10, 6'h21, 4'd2},  {2'b10, 6'h22, 4'd6},
    {2'b10, 6'h23, 4'd6},  {2'b10, 6'h24, 4'd0},  {2'b10, 6'h25, 4'd1},
    {2'b10, 6'h26, 4'd13}, {2'b10, 6'h27, 4'd12}, {2'b10, 6'h2A, 4'd15}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] ent;
    rst_n = 0; hold = 0; flush = 0;
    no_fwd();
    drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("reset ex_valid", W'(ex_valid), 0);
    chk("reset alu_ctl", W'(alu_ctl), 2);
    chk("reset ex_reg_write", W'(ex_reg_write), 0);
    rst_n = 1;
    tick();

    // add r3 = r1 + r2 with 5 and 7
    drive(1, 2'b10, 6'h20, 0, 1, 2, 3, 5, 7, 0, 1, 0, 0, 0);
    tick();
    chk("add alu_ctl", W'(alu_ctl), 2);
    chk("add alu_a", alu_a, 5);
    chk("add alu_b", alu_b, 7);
    chk("add ex_valid", W'(ex_valid), 1);

    // forwarding priority on a held rs=3
    drive(1, 2'b10, 6'h20, 0, 3, 2, 5, 32'h11, 32'h22, 0, 1, 0, 0, 0);
    tick();
    hold = 1;
    exmem_reg_write = 1; exmem_wr_reg = 3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_wr_reg = 3; memwb_result = 32'hBB;
    #1 chk("fwd exmem prio", alu_a, 32'hAA);
    chk("fwd store rt", ex_store_data, 32'h22);
    exmem_wr_reg = 0;
    #1 chk("fwd memwb", alu_a, 32'hBB);
    hold = 0;
    drive(1, 2'b10, 6'h20, 0, 0, 2, 5, 32'h33, 32'h22, 0, 1, 0, 0, 0);
    memwb_wr_reg = 0;
    tick();
    chk("fwd r0 never", alu_a, 32'h33);
    no_fwd();

    // load-use: lw r4 then a reader of r4
    drive(1, 2'b00, 6'h00, 1, 1, 4, 4, 32'h100, 0, 8, 1, 1, 0, 1);
    tick();
    drive(1, 2'b10, 6'h20, 0, 4, 2, 6, 1, 2, 0, 1, 0, 0, 0);
    #1 chk("lu stall rs", W'(idif.load_use_stall), 1);
    tick();
    chk("lu bubble", W'(ex_valid), 0);
    drive(1, 2'b00, 6'h00, 1, 1, 4, 4, 32'h100, 0, 8, 1, 1, 0, 1);
    tick();
    drive(1, 2'b00, 6'h00, 1, 1, 4, 7, 3, 9, 4, 1, 0, 0, 0);
    #1 chk("lu rt imm", W'(idif.load_use_stall), 0);
    idif.id_alu_src = 0;
    #1 chk("lu rt reg", W'(idif.load_use_stall), 1);
    tick(); tick();

    // hold with changing ID inputs; alu_a follows exmem
    drive(1, 2'b10, 6'h20, 0, 3, 2, 6, 32'h44, 32'h55, 0, 1, 0, 0, 0);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'($urandom_range(0, 3)), 6'($urandom), 1'($urandom), RW'(i + 8), RW'(i + 9),
            RW'(i + 10), $urandom, $urandom, $urandom, 1, 1, 1, 1);
      exmem_reg_write = 1; exmem_wr_reg = 3; exmem_result = W'(32'h100 + i);
      tick();
      chk("hold wr_reg", W'(ex_wr_reg), 6);
      chk("hold alu_a", alu_a, W'(32'h100 + i));
    end
    hold = 0;
    no_fwd();

    // flush beats hold
    drive(1, 2'b10, 6'h20, 0, 1, 2, 3, 5, 7, 0, 1, 0, 0, 0);
    tick();
    hold = 1; flush = 1;
    tick();
    chk("flush ex_valid", W'(ex_valid), 0);
    chk("flush ex_reg_write", W'(ex_reg_write), 0);
    hold = 0; flush = 0;

    // decode table, ending on slt (unsupported)
    for (int k = 0; k < 12; k++) begin
      ent = tbl[k];
      drive(1, ent[11:10], ent[9:4], 0, 1, 2, 3, 5, 7, 0, 1, 0, 0, 0);
      tick();
      chk("decode", W'(alu_ctl), W'(ent[3:0]));
    end
    chk("slt illegal", W'(ex_illegal), 1);

    // async reset mid-stream
    rst_n = 0;
    #1 chk("mid rst ex_valid", W'(ex_valid), 0);
    chk("mid rst alu_ctl", W'(alu_ctl), 2);
    chk("mid rst ex_illegal", W'(ex_illegal), 0);
    chk("mid rst ex_reg_write", W'(ex_reg_write), 0);
    chk("mid rst alu_a", alu_a, 0);
    tick();
    rst_n = 1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
